// File: rtl/fll_cfg_arbiter_pkg.sv
// rtl/fll_cfg_arbiter_pkg.sv - shared types and constants for the FLL config arbiter
package fll_cfg_arbiter_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      ACKLO,
      RESP,
      ERR,
      DRAIN
   } state_e;

   typedef struct packed {
      logic        wrn;
      logic [1:0]  add;
      logic [31:0] data;
   } cfg_req_t;

   localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/fll_cfg_arbiter_if.sv
// rtl/fll_cfg_arbiter_if.sv - config master bus shared by all masters of one arbiter
interface fll_cfg_arbiter_if #(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ-1:0]    wrn;
   logic [NUM_REQ*2-1:0]  add;
   logic [NUM_REQ*32-1:0] data;
   logic [NUM_REQ-1:0]    ack;
   logic                  err;
   logic [31:0]           r_data;

   modport master (
      output req, wrn, add, data,
      input  ack, err, r_data
   );

   modport slave (
      input  req, wrn, add, data,
      output ack, err, r_data
   );
endinterface

// File: rtl/fll_cfg_arbiter_rr_arb.sv
// rtl/fll_cfg_arbiter_rr_arb.sv - round-robin arbiter, lowest index at/after the pointer wins
module fll_cfg_rr_arb #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               update,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);
   logic [IDX_W-1:0] ptr;
   logic             found;

   // First pass covers indices at/after the pointer, second pass wraps around.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req[k] && (IDX_W'(k) >= ptr)) begin
            found    = 1'b1;
            grant[k] = 1'b1;
            idx      = IDX_W'(k);
         end
      end
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req[k]) begin
            found    = 1'b1;
            grant[k] = 1'b1;
            idx      = IDX_W'(k);
         end
      end
   end

   assign any = |req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (update) begin
         ptr <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
      end
   end
endmodule

// File: rtl/fll_cfg_arbiter_sync.sv
// rtl/fll_cfg_arbiter_sync.sv - multi-flop synchroniser cell for asynchronous FLL status
module fll_cfg_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
      end
   end

   assign q = sync_q[STAGES-1];
endmodule

// File: rtl/fll_cfg_arbiter.sv
// rtl/fll_cfg_arbiter.sv - shares one FLL config slave port among several masters
module fll_cfg_arbiter
   import fll_cfg_arbiter_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   fll_cfg_arbiter_if.slave    bus,
   output logic                fll_req,
   output logic                fll_wrn,
   output logic [1:0]          fll_add,
   output logic [31:0]         fll_data,
   input  logic                fll_ack,
   input  logic [31:0]         fll_r_data,
   input  logic                fll_lock,
   output logic                lock,
   input  logic                lock_cnt_clr,
   output logic [7:0]          lock_lost_cnt
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   state_e             state;
   cfg_req_t           cur;
   cfg_req_t           win_req;
   logic [IDX_W-1:0]   win_idx;
   logic [IDX_W-1:0]   grant_idx;
   logic [NUM_REQ-1:0] grant;
   logic [NUM_REQ-1:0] ack_q;
   logic               err_q;
   logic [31:0]        r_data_q;
   logic [31:0]        rcap;
   logic [TMR_W-1:0]   timer;
   logic               any_req;
   logic               grant_en;
   logic               ack_sync;
   logic               lock_sync;
   logic               lock_prev;
   logic [7:0]         lost_cnt;

   fll_cfg_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (fll_ack),
      .q     (ack_sync)
   );

   fll_cfg_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (fll_lock),
      .q     (lock_sync)
   );

   // No grant while the FLL still shows ack from an earlier access.
   assign grant_en = (state == IDLE) && any_req && !ack_sync;

   fll_cfg_rr_arb #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (bus.req),
      .update (grant_en),
      .grant  (grant),
      .idx    (grant_idx),
      .any    (any_req)
   );

   always_comb begin
      win_req = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            win_req.wrn  = bus.wrn[i];
            win_req.add  = bus.add[i*2 +: 2];
            win_req.data = bus.data[i*32 +: 32];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cur      <= '0;
         win_idx  <= '0;
         fll_req  <= 1'b0;
         ack_q    <= '0;
         err_q    <= 1'b0;
         r_data_q <= '0;
         rcap     <= '0;
         timer    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_en) begin
                  cur     <= win_req;
                  win_idx <= grant_idx;
                  fll_req <= 1'b1;
                  timer   <= '0;
                  state   <= REQ;
               end
            end
            REQ: begin
               if (ack_sync) begin
                  rcap    <= cur.wrn ? fll_r_data : 32'h0;
                  fll_req <= 1'b0;
                  timer   <= '0;
                  state   <= ACKLO;
               end else if (timer == TMR_LAST) begin
                  fll_req  <= 1'b0;
                  ack_q    <= NUM_REQ'(1) << win_idx;
                  err_q    <= 1'b1;
                  r_data_q <= ERR_RDATA;
                  state    <= ERR;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            ACKLO: begin
               if (!ack_sync) begin
                  ack_q    <= NUM_REQ'(1) << win_idx;
                  r_data_q <= rcap;
                  state    <= RESP;
               end else if (timer == TMR_LAST) begin
                  ack_q    <= NUM_REQ'(1) << win_idx;
                  err_q    <= 1'b1;
                  r_data_q <= ERR_RDATA;
                  state    <= ERR;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            RESP: begin
               ack_q    <= '0;
               r_data_q <= '0;
               state    <= IDLE;
            end
            ERR: begin
               ack_q    <= '0;
               err_q    <= 1'b0;
               r_data_q <= '0;
               state    <= DRAIN;
            end
            DRAIN: begin
               if (!ack_sync) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Clear wins over a same-cycle falling edge; count saturates at 255.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_prev <= 1'b0;
         lost_cnt  <= '0;
      end else begin
         lock_prev <= lock_sync;
         if (lock_cnt_clr) begin
            lost_cnt <= '0;
         end else if (lock_prev && !lock_sync && (lost_cnt != 8'hFF)) begin
            lost_cnt <= lost_cnt + 8'd1;
         end
      end
   end

   assign bus.ack       = ack_q;
   assign bus.err       = err_q;
   assign bus.r_data    = r_data_q;
   assign fll_wrn       = cur.wrn;
   assign fll_add       = cur.add;
   assign fll_data      = cur.data;
   assign lock          = lock_sync;
   assign lock_lost_cnt = lost_cnt;
endmodule
